hm_trn_conbus5: RTL and testbench

- Five-master to one-slave arbiter/multiplexer for the PCIe TRN transmit interface.
- Lets up to five TLP generators share the endpoint core's single Tx port.
- Grants whole packets (SOF..EOF) with round-robin priority.
- Sits between the host-memory Tx engines and the PCIe endpoint core.

---
 rtl/hm_trn_pkg.sv | 34 +++
 rtl/hm_trn_conbus5_if.sv | 27 ++
 rtl/hm_trn_rr_arb.sv | 27 ++
 rtl/hm_trn_conbus5.sv | 112 +++++++++++
 tb/tb_hm_trn_conbus5.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hm_trn_pkg.sv
// Shared types and constants for the five-master TRN transmit concentrator.
package hm_trn_pkg;

  localparam int unsigned NUM_MASTERS = 5;
  localparam int unsigned OWNER_W     = 3;
  localparam int unsigned TRN_DATA_W  = 64;
  localparam int unsigned TBUF_AV_W   = 6;

  typedef logic [OWNER_W-1:0] owner_t;

  typedef enum logic [0:0] {StIdle, StBusy} conbus_state_e;

  // Every source-driven TRN field that travels from a master to the slave.
  typedef struct packed {
    logic [TRN_DATA_W-1:0] td;
    logic                  trem_n;
    logic                  tsof_n;
    logic                  teof_n;
    logic                  tsrc_rdy_n;
    logic                  tsrc_dsc_n;
    logic                  terrfwd_n;
    logic                  tstr_n;
  } trn_beat_t;

  localparam trn_beat_t BEAT_IDLE = trn_beat_t'({{TRN_DATA_W{1'b0}}, 7'h7f});

  // Index reached by stepping 'step' places past 'base' around the master ring.
  function automatic owner_t rr_index(owner_t base, int unsigned step);
    int unsigned idx;
    idx = (32'(base) + step) % NUM_MASTERS;
    return owner_t'(idx);
  endfunction

endpackage

// File: rtl/hm_trn_conbus5_if.sv
// One TRN transmit link; 'master' is the TLP source side, 'slave' the sink side.
interface hm_trn_conbus5_if;
  import hm_trn_pkg::*;

  logic [TRN_DATA_W-1:0] td;
  logic                  trem_n;
  logic                  tsof_n;
  logic                  teof_n;
  logic                  tsrc_rdy_n;
  logic                  tsrc_dsc_n;
  logic                  terrfwd_n;
  logic                  tstr_n;
  logic [TBUF_AV_W-1:0]  tbuf_av;
  logic                  terr_drop_n;
  logic                  tdst_rdy_n;

  modport master (
    output td, trem_n, tsof_n, teof_n, tsrc_rdy_n, tsrc_dsc_n, terrfwd_n, tstr_n,
    input  tbuf_av, terr_drop_n, tdst_rdy_n
  );

  modport slave (
    input  td, trem_n, tsof_n, teof_n, tsrc_rdy_n, tsrc_dsc_n, terrfwd_n, tstr_n,
    output tbuf_av, terr_drop_n, tdst_rdy_n
  );

endinterface

// File: rtl/hm_trn_rr_arb.sv
// Combinational round-robin pick: first requester after 'last' around the ring.
module hm_trn_rr_arb
  import hm_trn_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  owner_t                 last,
  output logic                   valid,
  output owner_t                 winner
);

  owner_t cand;

  always_comb begin
    valid  = 1'b0;
    winner = last;
    cand   = last;
    // Step NUM_MASTERS ends on 'last' itself, so a lone previous owner still wins.
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      cand = rr_index(last, i);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/hm_trn_conbus5.sv
// Five-to-one TRN Tx concentrator: packet-granular round-robin grant and data mux.
module hm_trn_conbus5
  import hm_trn_pkg::*;
(
  input  logic            trn_clk,
  input  logic            trn_rst,
  hm_trn_conbus5_if.slave  m0_trn,
  hm_trn_conbus5_if.slave  m1_trn,
  hm_trn_conbus5_if.slave  m2_trn,
  hm_trn_conbus5_if.slave  m3_trn,
  hm_trn_conbus5_if.slave  m4_trn,
  hm_trn_conbus5_if.master s_trn
);

  conbus_state_e          state_q;
  owner_t                 owner_q;
  owner_t                 last_q;
  trn_beat_t              m_beat [NUM_MASTERS];
  trn_beat_t              own_beat;
  trn_beat_t              s_beat;
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] dst_rdy_n;
  logic [NUM_MASTERS-1:0] drop_n;
  logic                   arb_valid;
  owner_t                 arb_winner;
  logic                   pkt_end;

  assign m_beat[0] = {m0_trn.td, m0_trn.trem_n, m0_trn.tsof_n, m0_trn.teof_n,
                      m0_trn.tsrc_rdy_n, m0_trn.tsrc_dsc_n, m0_trn.terrfwd_n, m0_trn.tstr_n};
  assign m_beat[1] = {m1_trn.td, m1_trn.trem_n, m1_trn.tsof_n, m1_trn.teof_n,
                      m1_trn.tsrc_rdy_n, m1_trn.tsrc_dsc_n, m1_trn.terrfwd_n, m1_trn.tstr_n};
  assign m_beat[2] = {m2_trn.td, m2_trn.trem_n, m2_trn.tsof_n, m2_trn.teof_n,
                      m2_trn.tsrc_rdy_n, m2_trn.tsrc_dsc_n, m2_trn.terrfwd_n, m2_trn.tstr_n};
  assign m_beat[3] = {m3_trn.td, m3_trn.trem_n, m3_trn.tsof_n, m3_trn.teof_n,
                      m3_trn.tsrc_rdy_n, m3_trn.tsrc_dsc_n, m3_trn.terrfwd_n, m3_trn.tstr_n};
  assign m_beat[4] = {m4_trn.td, m4_trn.trem_n, m4_trn.tsof_n, m4_trn.teof_n,
                      m4_trn.tsrc_rdy_n, m4_trn.tsrc_dsc_n, m4_trn.terrfwd_n, m4_trn.tstr_n};

  always_comb begin
    req = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      req[k] = ~m_beat[k].tsrc_rdy_n & ~m_beat[k].tsof_n;
    end
  end

  hm_trn_rr_arb u_arb (
    .req    (req),
    .last   (last_q),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  always_comb begin
    own_beat  = m_beat[owner_q];
    s_beat    = BEAT_IDLE;
    dst_rdy_n = '1;
    drop_n    = '1;
    if (state_q == StBusy) begin
      s_beat             = own_beat;
      dst_rdy_n[owner_q] = s_trn.tdst_rdy_n;
      drop_n[owner_q]    = s_trn.terr_drop_n;
    end
  end

  // A discontinue ends the packet even while the slave is back-pressuring.
  assign pkt_end = (state_q == StBusy) && !own_beat.tsrc_rdy_n &&
                   ((!own_beat.teof_n && !s_trn.tdst_rdy_n) || !own_beat.tsrc_dsc_n);

  always_ff @(posedge trn_clk) begin
    if (trn_rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= OWNER_W'(NUM_MASTERS - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arb_valid) begin
            state_q <= StBusy;
            owner_q <= arb_winner;
          end
        end
        StBusy: begin
          if (pkt_end) begin
            state_q <= StIdle;
            last_q  <= owner_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign {s_trn.td, s_trn.trem_n, s_trn.tsof_n, s_trn.teof_n,
          s_trn.tsrc_rdy_n, s_trn.tsrc_dsc_n, s_trn.terrfwd_n, s_trn.tstr_n} = s_beat;

  assign m0_trn.tbuf_av     = s_trn.tbuf_av;
  assign m1_trn.tbuf_av     = s_trn.tbuf_av;
  assign m2_trn.tbuf_av     = s_trn.tbuf_av;
  assign m3_trn.tbuf_av     = s_trn.tbuf_av;
  assign m4_trn.tbuf_av     = s_trn.tbuf_av;
  assign m0_trn.tdst_rdy_n  = dst_rdy_n[0];
  assign m1_trn.tdst_rdy_n  = dst_rdy_n[1];
  assign m2_trn.tdst_rdy_n  = dst_rdy_n[2];
  assign m3_trn.tdst_rdy_n  = dst_rdy_n[3];
  assign m4_trn.tdst_rdy_n  = dst_rdy_n[4];
  assign m0_trn.terr_drop_n = drop_n[0];
  assign m1_trn.terr_drop_n = drop_n[1];
  assign m2_trn.terr_drop_n = drop_n[2];
  assign m3_trn.terr_drop_n = drop_n[3];
  assign m4_trn.terr_drop_n = drop_n[4];

endmodule

// File: tb/tb_hm_trn_conbus5.sv
// Scoreboard bench for hm_trn_conbus5: packet generators, reference arbiter model, monitor.
module tb_hm_trn_conbus5;
  import hm_trn_pkg::*;

  typedef struct packed {
    logic [4:0] dst_n;
    logic [4:0] drop_n;
    logic [5:0] tbuf;
    trn_beat_t  s;
  } cyc_t;

  logic trn_clk = 1'b0;
  logic trn_rst;
  always #5 trn_clk = ~trn_clk;

  hm_trn_conbus5_if m_if [NUM_MASTERS] ();
  hm_trn_conbus5_if s_if ();

  trn_beat_t  drv_beat [NUM_MASTERS];
  logic [5:0] drv_tbuf;
  logic       drv_dst_n;
  logic       drv_drop_n;
  logic [4:0] obs_dst_n;
  logic [4:0] obs_drop_n;
  logic [5:0] obs_tbuf [NUM_MASTERS];
  trn_beat_t  obs_s;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_m
    assign {m_if[g].td, m_if[g].trem_n, m_if[g].tsof_n, m_if[g].teof_n, m_if[g].tsrc_rdy_n,
            m_if[g].tsrc_dsc_n, m_if[g].terrfwd_n, m_if[g].tstr_n} = drv_beat[g];
    assign obs_dst_n[g]  = m_if[g].tdst_rdy_n;
    assign obs_drop_n[g] = m_if[g].terr_drop_n;
    assign obs_tbuf[g]   = m_if[g].tbuf_av;
  end

  assign s_if.tbuf_av     = drv_tbuf;
  assign s_if.tdst_rdy_n  = drv_dst_n;
  assign s_if.terr_drop_n = drv_drop_n;
  assign obs_s = {s_if.td, s_if.trem_n, s_if.tsof_n, s_if.teof_n, s_if.tsrc_rdy_n,
                  s_if.tsrc_dsc_n, s_if.terrfwd_n, s_if.tstr_n};

  hm_trn_conbus5 dut (
    .trn_clk (trn_clk),
    .trn_rst (trn_rst),
    .m0_trn  (m_if[0]),
    .m1_trn  (m_if[1]),
    .m2_trn  (m_if[2]),
    .m3_trn  (m_if[3]),
    .m4_trn  (m_if[4]),
    .s_trn   (s_if)
  );

  int        n_tests = 0;
  int        n_fail  = 0;
  cyc_t      cyc_q [$];
  trn_beat_t beat_q [$];

  // Reference model: who owns the slave (-1 = nobody) and who owned it last.
  int mdl_owner;
  int mdl_last;
  bit mdl_known;

  // Packet generators, one per master.
  bit g_act [NUM_MASTERS];
  bit g_rnd [NUM_MASTERS];
  int g_len [NUM_MASTERS];
  int g_beat [NUM_MASTERS];
  int g_dsc [NUM_MASTERS];
  int g_id [NUM_MASTERS];
  int pkt_id;

  bit rst_req;
  int slave_mode;   // 0 random, 1 always ready, 2 always stalled
  bit tbuf_rand;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic launch(input int k, input int len, input int dsc, input bit rnd);
    pkt_id++;
    g_act[k]  = 1'b1;
    g_rnd[k]  = rnd;
    g_len[k]  = len;
    g_beat[k] = 0;
    g_dsc[k]  = dsc;
    g_id[k]   = pkt_id;
  endtask

  task automatic build_inputs();
    for (int k = 0; k < NUM_MASTERS; k++) begin
      trn_beat_t b;
      b.trem_n    = g_rnd[k] ? 1'($urandom) : 1'b0;
      b.terrfwd_n = g_rnd[k] ? 1'($urandom) : 1'b1;
      b.tstr_n    = g_rnd[k] ? 1'($urandom) : 1'b1;
      if (g_act[k]) begin
        b.td         = {8'(k), 24'(g_id[k]), 32'(g_beat[k])};
        b.tsrc_rdy_n = g_rnd[k] && (g_beat[k] > 0) && ($urandom % 5 == 0);
        b.tsof_n     = (g_beat[k] != 0);
        b.teof_n     = (g_beat[k] != g_len[k] - 1);
        b.tsrc_dsc_n = (g_beat[k] != g_dsc[k]);
      end else begin
        b.td         = {$urandom, $urandom};
        b.tsrc_rdy_n = g_rnd[k] ? 1'($urandom) : 1'b1;
        b.tsof_n     = 1'b1;
        b.teof_n     = 1'($urandom);
        b.tsrc_dsc_n = 1'b1;
      end
      drv_beat[k] = b;
    end
    unique case (slave_mode)
      1:       drv_dst_n = 1'b0;
      2:       drv_dst_n = 1'b1;
      default: drv_dst_n = ($urandom % 3 == 0);
    endcase
    drv_drop_n = 1'($urandom);
    drv_tbuf   = tbuf_rand ? 6'($urandom) : 6'h2a;
    trn_rst    = rst_req;
  endtask

  task automatic model_push();
    cyc_t c;
    c.dst_n  = '1;
    c.drop_n = '1;
    c.tbuf   = drv_tbuf;
    c.s      = BEAT_IDLE;
    if (mdl_owner >= 0) begin
      c.s                 = drv_beat[mdl_owner];
      c.dst_n[mdl_owner]  = drv_dst_n;
      c.drop_n[mdl_owner] = drv_drop_n;
    end
    cyc_q.push_back(c);
    if (!c.s.tsrc_rdy_n) beat_q.push_back(c.s);
  endtask

  task automatic advance();
    int o;
    o = mdl_owner;
    if (rst_req) begin
      for (int k = 0; k < NUM_MASTERS; k++) g_act[k] = 1'b0;
      mdl_owner = -1;
      mdl_last  = NUM_MASTERS - 1;
      mdl_known = 1'b1;
    end else if (o >= 0) begin
      if (!drv_beat[o].tsrc_rdy_n && (!drv_beat[o].tsrc_dsc_n ||
          (!drv_beat[o].teof_n && !drv_dst_n))) begin
        mdl_last  = o;
        mdl_owner = -1;
      end
      if (g_act[o] && !drv_beat[o].tsrc_rdy_n) begin
        if (!drv_beat[o].tsrc_dsc_n) g_act[o] = 1'b0;
        else if (!drv_dst_n) begin
          if (g_beat[o] == g_len[o] - 1) g_act[o] = 1'b0;
          else g_beat[o]++;
        end
      end
    end else begin
      for (int i = 1; i <= NUM_MASTERS; i++) begin
        int idx;
        idx = (mdl_last + i) % NUM_MASTERS;
        if (mdl_owner < 0 && !drv_beat[idx].tsrc_rdy_n && !drv_beat[idx].tsof_n)
          mdl_owner = idx;
      end
    end
  endtask

  task automatic cycle();
    @(negedge trn_clk);
    build_inputs();
    #1;
    if (mdl_known) model_push();
    advance();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Monitor: every cycle compare handshake/broadcast outputs; pop a beat when the slave sees one.
  initial begin
    cyc_t c;
    trn_beat_t b;
    forever begin
      @(negedge trn_clk);
      #3;
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        chk("slave_bus", 128'(obs_s), 128'(c.s));
        chk("dst_rdy_n", 128'(obs_dst_n), 128'(c.dst_n));
        chk("err_drop_n", 128'(obs_drop_n), 128'(c.drop_n));
        for (int k = 0; k < NUM_MASTERS; k++) chk("tbuf_av", 128'(obs_tbuf[k]), 128'(c.tbuf));
        if (obs_s.tsrc_rdy_n === 1'b0) begin
          if (beat_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL beat_unexpected: got %h expected none", obs_s);
          end else begin
            b = beat_q.pop_front();
            chk("beat", 128'(obs_s), 128'(b));
          end
        end
      end
    end
  end

  initial begin
    mdl_owner  = -1;
    mdl_last   = NUM_MASTERS - 1;
    mdl_known  = 1'b0;
    pkt_id     = 0;
    slave_mode = 1;
    tbuf_rand  = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      g_act[k] = 1'b0;
      g_rnd[k] = 1'b0;
      g_len[k] = 1;
      g_beat[k] = 0;
      g_dsc[k] = -1;
      g_id[k] = 0;
    end
    rst_req = 1'b1;
    run(2);
    rst_req = 1'b0;
    run(2);

    launch(2, 3, -1, 1'b0);
    run(8);
    launch(0, 2, -1, 1'b0);
    launch(3, 2, -1, 1'b0);
    run(10);
    launch(1, 4, -1, 1'b0);
    run(2);
    launch(4, 2, -1, 1'b0);
    run(12);
    slave_mode = 2;
    launch(0, 1, -1, 1'b0);
    run(6);
    slave_mode = 1;
    run(4);
    launch(3, 4, 2, 1'b0);
    run(8);
    launch(3, 5, -1, 1'b0);
    run(3);
    rst_req = 1'b1;
    run(1);
    rst_req = 1'b0;
    run(1);
    launch(3, 2, -1, 1'b0);
    launch(0, 2, -1, 1'b0);
    run(10);

    slave_mode = 0;
    tbuf_rand  = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (!g_act[k] && ($urandom % 6 == 0)) begin
          int len;
          len = 1 + int'($urandom % 6);
          launch(k, len, (len > 1 && $urandom % 10 == 0) ? 1 + int'($urandom % (len - 1)) : -1,
                 1'b1);
        end
      end
      rst_req = ($urandom % 300 == 0);
      cycle();
    end
    rst_req    = 1'b0;
    slave_mode = 1;
    run(60);

    @(negedge trn_clk);
    #4;
    chk("beats_drained", 128'(beat_q.size()), 128'(0));
    chk("cycles_drained", 128'(cyc_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
